// File: rtl/id_stage_pipe.sv
// ID stage: 6-bit-opcode decode, register file read, ID/EX pipeline register with
// valid/ready handshakes, load-use stall, flush and HALT FSM. Optional macro: ID_WB_BYPASS_EN.
module id_stage_pipe #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       inst,
    input  logic              wb_we,
    input  logic [AW-1:0]     wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5:0]        out_opcode,
    output logic [DATA_W-1:0] out_rs_val,
    output logic [DATA_W-1:0] out_rt_val,
    output logic [DATA_W-1:0] out_imm,
    output logic [AW-1:0]     out_dest,
    output logic              out_we,
    output logic              out_is_load,
    output logic              out_is_store,
    output logic              out_is_branch,
    output logic              halted
);

    typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_e;

    state_e state_q, state_d;
    logic   run;

    logic [DATA_W-1:0] rf_q [NUM_REGS];

    logic              out_valid_q, out_valid_d;
    logic [5:0]        out_opcode_q;
    logic [DATA_W-1:0] out_rs_val_q, out_rt_val_q, out_imm_q;
    logic [AW-1:0]     out_dest_q;
    logic              out_we_q, out_is_load_q, out_is_store_q, out_is_branch_q;

    logic [5:0]        opcode;
    logic [AW-1:0]     rs, rt, rd;
    logic [DATA_W-1:0] imm;
    logic              dec_legal, dec_we, dec_load, dec_store, dec_branch, dec_halt;
    logic              reads_rs, reads_rt;
    logic [AW-1:0]     dec_dest;
    logic [DATA_W-1:0] rs_val, rt_val;
    logic              wb_wr, adv, hazard, accept, load_en;

    assign opcode = inst[31:26];
    assign rs     = inst[21 +: AW];
    assign rt     = inst[16 +: AW];
    assign rd     = inst[11 +: AW];
    assign imm    = {{(DATA_W-16){inst[15]}}, inst[15:0]};

    always_comb begin
        dec_legal  = 1'b0;
        dec_we     = 1'b0;
        dec_load   = 1'b0;
        dec_store  = 1'b0;
        dec_branch = 1'b0;
        dec_halt   = 1'b0;
        reads_rs   = 1'b0;
        reads_rt   = 1'b0;
        dec_dest   = '0;
        case (opcode)
            6'd0, 6'd2, 6'd4, 6'd6, 6'd8, 6'd10: begin
                dec_legal = 1'b1; dec_we = 1'b1; dec_dest = rd;
                reads_rs  = 1'b1; reads_rt = 1'b1;
            end
            6'd1, 6'd3, 6'd5, 6'd7, 6'd9, 6'd11, 6'd12: begin
                dec_legal = 1'b1; dec_we = 1'b1; dec_dest = rt;
                reads_rs  = 1'b1; dec_load = (opcode == 6'd12);
            end
            6'd13: begin
                dec_legal = 1'b1; dec_store = 1'b1;
                reads_rs  = 1'b1; reads_rt  = 1'b1;
            end
            6'd14, 6'd16: begin
                dec_legal = 1'b1; dec_branch = 1'b1; reads_rs = 1'b1;
            end
            6'd15: begin
                dec_legal = 1'b1; dec_branch = 1'b1;
                reads_rs  = 1'b1; reads_rt   = 1'b1;
            end
            6'd17: begin
                dec_legal = 1'b1; dec_halt = 1'b1;
            end
            default: ;
        endcase
    end

    assign wb_wr = wb_we && (wb_addr != '0);

    always_comb begin
        rs_val = (rs == '0) ? '0 : rf_q[rs];
        rt_val = (rt == '0) ? '0 : rf_q[rt];
`ifdef ID_WB_BYPASS_EN
        // wb_wr already excludes r0, so a match implies a nonzero source index
        if (wb_wr && (wb_addr == rs)) rs_val = wb_data;
        if (wb_wr && (wb_addr == rt)) rt_val = wb_data;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
        end else if (wb_wr) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    assign adv    = !out_valid_q || out_ready;
    assign hazard = out_valid_q && out_is_load_q && (out_dest_q != '0) &&
                    ((reads_rs && (out_dest_q == rs)) || (reads_rt && (out_dest_q == rt)));
    assign in_ready = adv && !hazard && run && !flush;
    assign accept   = in_valid && in_ready;
    assign load_en  = accept && dec_legal;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush)                                     state_d = RUN;
        else if (state_q == RUN && accept && dec_halt) state_d = HALTED;
    end

    always_comb begin
        run    = (state_q == RUN);
        halted = (state_q == HALTED);
    end

    always_comb begin
        out_valid_d = out_valid_q;
        if (flush)    out_valid_d = 1'b0;
        else if (adv) out_valid_d = load_en;
    end

    // load_en implies adv and no flush, so the bundle only changes on a real load
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q     <= 1'b0;
            out_opcode_q    <= '0;
            out_rs_val_q    <= '0;
            out_rt_val_q    <= '0;
            out_imm_q       <= '0;
            out_dest_q      <= '0;
            out_we_q        <= 1'b0;
            out_is_load_q   <= 1'b0;
            out_is_store_q  <= 1'b0;
            out_is_branch_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            if (load_en) begin
                out_opcode_q    <= opcode;
                out_rs_val_q    <= rs_val;
                out_rt_val_q    <= rt_val;
                out_imm_q       <= imm;
                out_dest_q      <= dec_dest;
                out_we_q        <= dec_we;
                out_is_load_q   <= dec_load;
                out_is_store_q  <= dec_store;
                out_is_branch_q <= dec_branch;
            end
        end
    end

    assign out_valid     = out_valid_q;
    assign out_opcode    = out_opcode_q;
    assign out_rs_val    = out_rs_val_q;
    assign out_rt_val    = out_rt_val_q;
    assign out_imm       = out_imm_q;
    assign out_dest      = out_dest_q;
    assign out_we        = out_we_q;
    assign out_is_load   = out_is_load_q;
    assign out_is_store  = out_is_store_q;
    assign out_is_branch = out_is_branch_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed scenarios plus randomized traffic checked against
// a transaction-level reference model; honours ID_WB_BYPASS_EN when defined.
module tb_id_stage_pipe;

    logic        clk, reset, in_valid, in_ready, wb_we, flush, out_valid, out_ready;
    logic [31:0] inst, wb_data, out_rs_val, out_rt_val, out_imm;
    logic [4:0]  wb_addr, out_dest;
    logic [5:0]  out_opcode;
    logic        out_we, out_is_load, out_is_store, out_is_branch, halted;

    int checks = 0;
    int failures = 0;

`ifdef ID_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    id_stage_pipe #(.DATA_W(32), .NUM_REGS(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
        .out_rs_val(out_rs_val), .out_rt_val(out_rt_val), .out_imm(out_imm),
        .out_dest(out_dest), .out_we(out_we), .out_is_load(out_is_load),
        .out_is_store(out_is_store), .out_is_branch(out_is_branch), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: instruction classes from the opcode table, architectural
    // register array, and the single ID/EX slot the stage exposes.
    typedef struct packed {
        logic legal, we, ld, st, br, halt, rrs, rrt;
        logic [4:0] dest;
    } dec_t;

    logic [31:0] m_rf [32];
    logic        m_ov, m_we, m_ld, m_st, m_br, m_halted;
    logic [5:0]  m_op;
    logic [31:0] m_rs, m_rt, m_imm;
    logic [4:0]  m_dest;

    function automatic dec_t ref_decode(input logic [31:0] i);
        dec_t d;
        int   op;
        op = int'(i[31:26]);
        d  = '0;
        if (op <= 11 && op % 2 == 0) begin
            d.legal = 1; d.we = 1; d.rrs = 1; d.rrt = 1; d.dest = i[15:11];
        end else if (op <= 12) begin
            d.legal = 1; d.we = 1; d.rrs = 1; d.dest = i[20:16]; d.ld = (op == 12);
        end else if (op == 13) begin
            d.legal = 1; d.st = 1; d.rrs = 1; d.rrt = 1;
        end else if (op <= 16) begin
            d.legal = 1; d.br = 1; d.rrs = 1; d.rrt = (op == 15);
        end else if (op == 17) begin
            d.legal = 1; d.halt = 1;
        end
        return d;
    endfunction

    function automatic logic [31:0] mread(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (BYP && wb_we && wb_addr == a) return wb_data;
        return m_rf[a];
    endfunction

    function automatic logic model_in_ready();
        dec_t d;
        logic haz;
        d   = ref_decode(inst);
        haz = m_ov && m_ld && m_dest != 5'd0 &&
              ((d.rrs && m_dest == inst[25:21]) || (d.rrt && m_dest == inst[20:16]));
        return (!m_ov || out_ready) && !haz && !m_halted && !flush;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_ov <= 0; m_we <= 0; m_ld <= 0; m_st <= 0; m_br <= 0; m_halted <= 0;
            m_op <= 0; m_rs <= 0; m_rt <= 0; m_imm <= 0; m_dest <= 0;
            for (int k = 0; k < 32; k++) m_rf[k] <= 32'd0;
        end else begin : step
            dec_t d;
            logic acc;
            d   = ref_decode(inst);
            acc = in_valid && model_in_ready();
            if (flush) begin
                m_ov <= 0; m_halted <= 0;
            end else begin
                if (!m_ov || out_ready) m_ov <= acc && d.legal;
                if (acc && d.legal) begin
                    m_op <= inst[31:26]; m_rs <= mread(inst[25:21]); m_rt <= mread(inst[20:16]);
                    m_imm <= {{16{inst[15]}}, inst[15:0]}; m_dest <= d.dest;
                    m_we <= d.we; m_ld <= d.ld; m_st <= d.st; m_br <= d.br;
                end
                if (acc && d.halt) m_halted <= 1;
            end
            if (wb_we && wb_addr != 5'd0) m_rf[wb_addr] <= wb_data;
        end
    end

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_we = 1; wb_addr = a; wb_data = d;
        @(negedge clk);
        wb_we = 0;
    endtask

    task automatic send(input logic [31:0] i);
        in_valid = 1; inst = i;
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic test_reset();
        reset = 0; in_valid = 0; inst = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
        flush = 0; out_ready = 1;
        #12;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0h exp=0", out_valid); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rst_halted got=%0h exp=0", halted); end
        checks++; if ({out_opcode, out_rs_val, out_rt_val, out_imm, out_dest} !== '0) begin
            failures++; $display("FAIL rst_fields got op=%0h rs=%0h rt=%0h imm=%0h dest=%0h exp=0",
                                 out_opcode, out_rs_val, out_rt_val, out_imm, out_dest); end
        checks++; if ({out_we, out_is_load, out_is_store, out_is_branch} !== 4'b0) begin
            failures++; $display("FAIL rst_flags got=%b exp=0000", {out_we, out_is_load, out_is_store, out_is_branch}); end
        @(negedge clk); reset = 1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%0h exp=1", in_ready); end
    endtask

    task automatic test_add();
        wb_write(5'd3, 32'h5);
        wb_write(5'd4, 32'h7);
        send(32'h00642800);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL add_valid got=%0h exp=1", out_valid); end
        checks++; if (out_rs_val !== 32'h5) begin failures++; $display("FAIL add_rs got=%0h exp=5", out_rs_val); end
        checks++; if (out_rt_val !== 32'h7) begin failures++; $display("FAIL add_rt got=%0h exp=7", out_rt_val); end
        checks++; if (out_dest !== 5'd5) begin failures++; $display("FAIL add_dest got=%0d exp=5", out_dest); end
        checks++; if (out_we !== 1'b1) begin failures++; $display("FAIL add_we got=%0h exp=1", out_we); end
    endtask

    task automatic test_imm();
        send({6'd1, 5'd3, 5'd6, 16'hFFFE});
        checks++; if (out_imm !== 32'hFFFF_FFFE) begin failures++; $display("FAIL imm_sext got=%0h exp=fffffffe", out_imm); end
        checks++; if (out_dest !== 5'd6) begin failures++; $display("FAIL imm_dest got=%0d exp=6", out_dest); end
        checks++; if (out_we !== 1'b1) begin failures++; $display("FAIL imm_we got=%0h exp=1", out_we); end
        checks++; if (out_is_load !== 1'b0) begin failures++; $display("FAIL imm_is_load got=%0h exp=0", out_is_load); end
        checks++; if (out_rs_val !== 32'h5) begin failures++; $display("FAIL imm_rs got=%0h exp=5", out_rs_val); end
        send({6'd1, 5'd3, 5'd6, 16'h7FFF});
        checks++; if (out_imm !== 32'h0000_7FFF) begin failures++; $display("FAIL imm_pos got=%0h exp=7fff", out_imm); end
    endtask

    task automatic test_load_use();
        out_ready = 1;
        in_valid = 1; inst = {6'd12, 5'd3, 5'd7, 16'd4};
        @(negedge clk);
        checks++; if (out_is_load !== 1'b1 || out_valid !== 1'b1) begin
            failures++; $display("FAIL ldw_issue got ld=%0h v=%0h exp=1,1", out_is_load, out_valid); end
        inst = {6'd0, 5'd7, 5'd0, 5'd1, 11'd0};
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL lu_stall_ready got=%0h exp=0", in_ready); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL lu_bubble got=%0h exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL lu_release got=%0h exp=1", in_ready); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_dest !== 5'd1 || out_opcode !== 6'd0) begin
            failures++; $display("FAIL lu_after got v=%0h dest=%0d op=%0d exp=1,1,0", out_valid, out_dest, out_opcode); end
        inst = {6'd12, 5'd3, 5'd0, 16'd0};
        @(negedge clk);
        inst = {6'd0, 5'd0, 5'd0, 5'd2, 11'd0};
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL lu_r0_nostall got=%0h exp=1", in_ready); end
        @(negedge clk);
        in_valid = 0;
        checks++; if (out_valid !== 1'b1 || out_dest !== 5'd2) begin
            failures++; $display("FAIL lu_r0_issue got v=%0h dest=%0d exp=1,2", out_valid, out_dest); end
    endtask

    task automatic test_backpressure();
        send(32'h00642800);
        out_ready = 0; in_valid = 1; inst = {6'd2, 5'd3, 5'd4, 5'd9, 11'd0};
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready[%0d] got=%0h exp=0", c, in_ready); end
            @(negedge clk);
            checks++; if (out_valid !== 1'b1 || out_opcode !== 6'd0 || out_rs_val !== 32'h5 ||
                          out_rt_val !== 32'h7 || out_dest !== 5'd5 || out_we !== 1'b1) begin
                failures++; $display("FAIL bp_hold[%0d] got v=%0h op=%0d rs=%0h rt=%0h dest=%0d exp=1,0,5,7,5",
                                     c, out_valid, out_opcode, out_rs_val, out_rt_val, out_dest); end
        end
        out_ready = 1;
        @(negedge clk);
        in_valid = 0;
        checks++; if (out_opcode !== 6'd2 || out_dest !== 5'd9) begin
            failures++; $display("FAIL bp_resume got op=%0d dest=%0d exp=2,9", out_opcode, out_dest); end
        wb_write(5'd0, 32'hDEAD);
        send({6'd0, 5'd0, 5'd0, 5'd8, 11'd0});
        checks++; if (out_rs_val !== 32'h0 || out_rt_val !== 32'h0) begin
            failures++; $display("FAIL r0_read got rs=%0h rt=%0h exp=0,0", out_rs_val, out_rt_val); end
    endtask

    task automatic test_halt_flush();
        send({6'd17, 26'd0});
        checks++; if (halted !== 1'b1 || out_valid !== 1'b1 || out_opcode !== 6'd17) begin
            failures++; $display("FAIL halt_enter got h=%0h v=%0h op=%0d exp=1,1,17", halted, out_valid, out_opcode); end
        in_valid = 1; inst = 32'h00642800;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL halt_ready got=%0h exp=0", in_ready); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || halted !== 1'b1) begin
            failures++; $display("FAIL halt_drain got v=%0h h=%0h exp=0,1", out_valid, halted); end
        flush = 1;
        @(negedge clk);
        flush = 0; in_valid = 0;
        checks++; if (halted !== 1'b0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL flush_exit got h=%0h v=%0h exp=0,0", halted, out_valid); end
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got=%0h exp=1", in_ready); end
        send(32'h00642800);
        in_valid = 1; flush = 1;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_blocks got=%0h exp=0", in_ready); end
        @(negedge clk);
        flush = 0; in_valid = 0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_drop got=%0h exp=0", out_valid); end
    endtask

    task automatic test_bypass();
        wb_write(5'd9, 32'h1111);
        wb_we = 1; wb_addr = 5'd9; wb_data = 32'h1234;
        in_valid = 1; inst = {6'd2, 5'd9, 5'd0, 5'd1, 11'd0};
        @(negedge clk);
        wb_we = 0; in_valid = 0;
        checks++; if (out_rs_val !== (BYP ? 32'h1234 : 32'h1111)) begin
            failures++; $display("FAIL bypass_rs got=%0h exp=%0h", out_rs_val, BYP ? 32'h1234 : 32'h1111); end
        send({6'd2, 5'd9, 5'd0, 5'd1, 11'd0});
        checks++; if (out_rs_val !== 32'h1234) begin failures++; $display("FAIL wb_landed got=%0h exp=1234", out_rs_val); end
    endtask

    task automatic test_reset_mid();
        send(32'h00642800);
        #2 reset = 0;
        #1;
        checks++; if (out_valid !== 1'b0 || halted !== 1'b0 || out_rs_val !== 32'h0) begin
            failures++; $display("FAIL mid_reset got v=%0h h=%0h rs=%0h exp=0,0,0", out_valid, halted, out_rs_val); end
        @(negedge clk); reset = 1;
        @(negedge clk);
        send(32'h00642800);
        checks++; if (out_rs_val !== 32'h0 || out_rt_val !== 32'h0) begin
            failures++; $display("FAIL mid_reset_rf got rs=%0h rt=%0h exp=0,0", out_rs_val, out_rt_val); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            int r, op;
            logic exp_ir;
            r = $urandom_range(0, 99);
            if (r < 5)      op = $urandom_range(18, 63);
            else if (r < 7) op = 17;
            else            op = $urandom_range(0, 16);
            inst      = {op[5:0], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            wb_we     = ($urandom_range(0, 1) != 0);
            wb_addr   = 5'($urandom_range(0, 7));
            wb_data   = $urandom;
            #1;
            exp_ir = model_in_ready();
            checks++; if (in_ready !== exp_ir) begin
                failures++; $display("FAIL rnd_in_ready[%0d] got=%0h exp=%0h", n, in_ready, exp_ir); end
            @(negedge clk);
            checks++; if (out_valid !== m_ov || halted !== m_halted) begin
                failures++; $display("FAIL rnd_state[%0d] got v=%0h h=%0h exp=%0h,%0h", n, out_valid, halted, m_ov, m_halted); end
            if (m_ov) begin
                checks++;
                if (out_opcode !== m_op || out_rs_val !== m_rs || out_rt_val !== m_rt || out_imm !== m_imm ||
                    out_we !== m_we || out_is_load !== m_ld || out_is_store !== m_st ||
                    out_is_branch !== m_br || (m_we && out_dest !== m_dest)) begin
                    failures++;
                    $display("FAIL rnd_bundle[%0d] got op=%0d rs=%0h rt=%0h imm=%0h d=%0d f=%b exp op=%0d rs=%0h rt=%0h imm=%0h d=%0d f=%b",
                             n, out_opcode, out_rs_val, out_rt_val, out_imm, out_dest,
                             {out_we, out_is_load, out_is_store, out_is_branch},
                             m_op, m_rs, m_rt, m_imm, m_dest, {m_we, m_ld, m_st, m_br});
                end
            end
        end
        in_valid = 0; flush = 0; wb_we = 0; out_ready = 1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_imm();
        test_load_use();
        test_backpressure();
        test_halt_flush();
        test_bypass();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
